// File: rtl/latch_pkg.sv
// Shared state encoding and default parameters for the latch synchroniser/monitor.
package latch_pkg;
  typedef enum logic {
    IDLE  = 1'b0,
    CHECK = 1'b1
  } state_t;

  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_DEBOUNCE    = 4;
  localparam int DEF_CNT_W       = 8;
endpackage

// File: rtl/sync_chain.sv
// Plain shift-register synchroniser: d enters stage 0, q is the last stage.
module sync_chain
  import latch_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [SYNC_STAGES-1:0] r_chain;

  always_ff @(posedge clk) begin
    if (rst) r_chain <= '0;
    else     r_chain <= {r_chain[SYNC_STAGES-2:0], d};
  end

  assign q = r_chain[SYNC_STAGES-1];
endmodule

// File: rtl/latch_sync_monitor.sv
// Synchronises and debounces a latch output, emits edge pulses, counts changes
// and holds the most recent change in a valid/ack event register.
module latch_sync_monitor
  import latch_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int DEBOUNCE    = DEF_DEBOUNCE,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             q_in,
  input  logic             clr,
  input  logic             rd_ack,
  output logic             q_sync,
  output logic             q_stable,
  output logic             rise,
  output logic             fall,
  output logic [CNT_W-1:0] evt_cnt,
  output logic             ovf,
  output logic             evt_valid,
  output logic             evt_level,
  output logic             evt_miss
);
  localparam int DBW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE - 1);
  localparam logic [DBW-1:0] DB_ONE  = DBW'(1);

  logic             w_sync;
  state_t           r_state, w_state_nxt;
  logic [DBW-1:0]   r_dbcnt, w_dbcnt_nxt;
  logic             w_commit;
  logic             r_stable, r_rise, r_fall;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf, r_valid, r_level, r_miss;

  sync_chain #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (q_in),
    .q   (w_sync)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_dbcnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_dbcnt <= w_dbcnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_dbcnt_nxt = r_dbcnt;
    w_commit    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_sync != r_stable) begin
          if (DEBOUNCE == 1) begin
            w_commit = 1'b1;
          end else begin
            w_state_nxt = CHECK;
            w_dbcnt_nxt = DB_ONE;
          end
        end
      end
      CHECK: begin
        if (w_sync == r_stable) begin
          w_state_nxt = IDLE;
          w_dbcnt_nxt = '0;
        end else if (r_dbcnt == DB_LAST) begin
          w_commit    = 1'b1;
          w_state_nxt = IDLE;
          w_dbcnt_nxt = '0;
        end else begin
          w_dbcnt_nxt = r_dbcnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_dbcnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stable <= 1'b0;
      r_rise   <= 1'b0;
      r_fall   <= 1'b0;
      r_cnt    <= '0;
      r_ovf    <= 1'b0;
      r_valid  <= 1'b0;
      r_level  <= 1'b0;
      r_miss   <= 1'b0;
    end else begin
      r_rise <= w_commit &  w_sync;
      r_fall <= w_commit & ~w_sync;
      if (w_commit) r_stable <= w_sync;

      // clr takes priority over a coincident commit for the statistics
      if (clr) begin
        r_cnt <= '0;
        r_ovf <= 1'b0;
      end else if (w_commit) begin
        if (r_cnt == '1) r_ovf <= 1'b1;
        else             r_cnt <= r_cnt + 1'b1;
      end

      if (clr)                                 r_miss <= 1'b0;
      else if (w_commit && r_valid && !rd_ack) r_miss <= 1'b1;

      if (w_commit) begin
        r_valid <= 1'b1;
        r_level <= w_sync;
      end else if (rd_ack) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign q_sync    = w_sync;
  assign q_stable  = r_stable;
  assign rise      = r_rise;
  assign fall      = r_fall;
  assign evt_cnt   = r_cnt;
  assign ovf       = r_ovf;
  assign evt_valid = r_valid;
  assign evt_level = r_level;
  assign evt_miss  = r_miss;
endmodule

// File: tb/tb_latch_sync_monitor.sv
// Directed bench: default instance plus a CNT_W=2 instance for saturation.
module tb_latch_sync_monitor;
  logic clk = 1'b0;
  logic rst, q_in, clr, clr_s, rd_ack;

  logic       q_sync, q_stable, rise, fall, ovf, evt_valid, evt_level, evt_miss;
  logic [7:0] evt_cnt;
  logic       s_q_sync, s_q_stable, s_rise, s_fall, s_ovf, s_valid, s_level, s_miss;
  logic [1:0] s_cnt;

  int npass = 0;
  int ntot  = 0;

  always #5 clk = ~clk;

  latch_sync_monitor dut (
    .clk(clk), .rst(rst), .q_in(q_in), .clr(clr), .rd_ack(rd_ack),
    .q_sync(q_sync), .q_stable(q_stable), .rise(rise), .fall(fall),
    .evt_cnt(evt_cnt), .ovf(ovf), .evt_valid(evt_valid),
    .evt_level(evt_level), .evt_miss(evt_miss)
  );

  latch_sync_monitor #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .q_in(q_in), .clr(clr_s), .rd_ack(rd_ack),
    .q_sync(s_q_sync), .q_stable(s_q_stable), .rise(s_rise), .fall(s_fall),
    .evt_cnt(s_cnt), .ovf(s_ovf), .evt_valid(s_valid),
    .evt_level(s_level), .evt_miss(s_miss)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ntot++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic pulsed;
    rst = 1'b1; q_in = 1'b1; clr = 1'b0; clr_s = 1'b0; rd_ack = 1'b0;

    // reset and first change
    tick(2);
    chk("rst_outs", {q_sync, q_stable, rise, fall, ovf, evt_valid, evt_level, evt_miss}, 0);
    chk("rst_cnt", evt_cnt, 0);
    rst = 1'b0;
    tick(1);
    chk("sync_e1", q_sync, 0);
    tick(1);
    chk("sync_e2", q_sync, 1);
    tick(3);
    chk("stable_e5", {q_stable, rise}, 2'b00);
    tick(1);
    chk("commit_e6", {q_stable, rise, fall}, 3'b110);
    chk("cnt_1", evt_cnt, 1);
    chk("evt_1", {evt_valid, evt_level, evt_miss}, 3'b110);
    tick(1);
    chk("rise_1cyc", rise, 0);

    // overwrite without ack
    q_in = 1'b0;
    tick(6);
    chk("fall_commit", {q_stable, rise, fall}, 3'b001);
    chk("overwrite", {evt_valid, evt_level, evt_miss}, 3'b101);
    chk("cnt_2", evt_cnt, 2);
    rd_ack = 1'b1;
    tick(1);
    rd_ack = 1'b0;
    chk("ack_clears", evt_valid, 0);
    rd_ack = 1'b1;
    tick(1);
    rd_ack = 1'b0;
    chk("ack_idle_ignored", {evt_valid, evt_miss}, 2'b01);

    // 3-cycle glitch
    pulsed = 1'b0;
    q_in = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (i == 3) q_in = 1'b0;
      tick(1);
      if (rise || fall || q_stable) pulsed = 1'b1;
    end
    chk("glitch_quiet", pulsed, 0);
    chk("glitch_cnt", evt_cnt, 2);

    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    chk("clr_main", {evt_cnt, ovf, evt_miss}, 0);

    // rise commit into empty register; sat instance commit #3
    q_in = 1'b1;
    tick(6);
    chk("rise2", {rise, evt_valid, evt_level, evt_miss}, 4'b1110);
    chk("cnt_after_clr", evt_cnt, 1);

    // fall commit coincident with ack; sat instance commit #4
    q_in = 1'b0;
    tick(5);
    rd_ack = 1'b1;
    tick(1);
    rd_ack = 1'b0;
    chk("ack_commit", {fall, evt_valid, evt_level, evt_miss}, 4'b1100);
    chk("sat_cnt", s_cnt, 3);
    chk("sat_ovf", s_ovf, 1);
    chk("sat_miss", s_miss, 1);
    clr_s = 1'b1;
    tick(1);
    clr_s = 1'b0;
    chk("sat_clr", {s_cnt, s_ovf, s_miss}, 0);

    // clr coincident with a commit
    q_in = 1'b1;
    tick(5);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    chk("clr_commit_cnt", evt_cnt, 0);
    chk("clr_commit_evt", {rise, q_stable, evt_valid, evt_level, evt_miss}, 5'b11110);

    // reset during CHECK with dbcnt=2
    q_in = 1'b0;
    tick(6);
    chk("pre_mid_fall", {q_stable, fall}, 2'b01);
    q_in = 1'b1;
    tick(4);
    rst = 1'b1;
    tick(1);
    chk("mid_rst", {q_sync, q_stable, evt_valid, evt_cnt}, 0);
    rst = 1'b0;
    tick(5);
    chk("mid_no_early", {q_stable, rise}, 2'b00);
    tick(1);
    chk("mid_commit_e6", {q_stable, rise, evt_cnt}, {2'b11, 8'd1});

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench exceeded time limit");
    $fatal(1);
  end
endmodule

// File: doc/latch_sync_monitor.md
Name: latch_sync_monitor

Overview:
- Clocked monitor that consumes the asynchronous q output of a d_latch stage.
- Synchronises q into the clock domain and debounces it.
- Emits one-cycle rise/fall pulses and counts committed level changes with a saturating counter.
- Presents each change to a downstream reader through a valid/ack event register.

Parameters:
SYNC_STAGES, 2, number of flip-flops in the synchroniser chain (minimum 2)
DEBOUNCE, 4, consecutive sampled cycles q_sync must differ from q_stable before the change commits (minimum 1)
CNT_W, 8, width of the event counter

Ports:
clk  input  1  single clock; all logic on the rising edge
rst  input  1  synchronous, active-high reset
q_in  input  1  asynchronous latch output to monitor
clr  input  1  synchronous clear of evt_cnt, ovf and evt_miss
rd_ack  input  1  reader accepts the current event
q_sync  output  1  last stage of the synchroniser chain
q_stable  output  1  debounced level
rise  output  1  one-cycle pulse on a committed 0->1 change
fall  output  1  one-cycle pulse on a committed 1->0 change
evt_cnt  output  CNT_W  saturating count of committed changes
ovf  output  1  sticky; set when an increment is attempted at the all-ones count
evt_valid  output  1  an unread event is held
evt_level  output  1  new level of the held event
evt_miss  output  1  sticky; an event was overwritten before it was acked

Behaviour:
- Reset (rst=1 at a clock edge): the whole sync chain, q_stable, rise, fall, evt_cnt, ovf, evt_valid, evt_level, evt_miss and the debounce counter all go to 0, and the FSM goes to IDLE.
  - rst overrides every other input.
  - Reset mid-debounce discards the pending change.
- Synchroniser: a plain shift chain of SYNC_STAGES flops. There is no logic between the stages.
- Debounce FSM has two states:
  - IDLE: q_sync == q_stable. If q_sync != q_stable, go to CHECK with dbcnt=1. If DEBOUNCE==1, commit immediately instead.
  - CHECK: if q_sync == q_stable (glitch), go to IDLE with dbcnt=0 and no output activity. Else if dbcnt == DEBOUNCE-1, commit. Else dbcnt++.
- Commit (registered, all effects at the same edge):
  - q_stable <= q_sync.
  - rise <= q_sync, fall <= ~q_sync; each pulse lasts exactly one cycle.
  - FSM returns to IDLE.
- Latency:
  - q_sync changes SYNC_STAGES edges after the q_in change.
  - q_stable, rise and fall change DEBOUNCE edges after q_sync first shows the new value.
- Counter:
  - On commit, evt_cnt increments if below 2^CNT_W-1.
  - At 2^CNT_W-1 the count holds and ovf is set.
  - clr=1 forces evt_cnt=0, ovf=0 and evt_miss=0. clr wins over a simultaneous commit, so the count stays 0.
- Event handshake:
  - On commit, evt_valid is set and evt_level takes the new level.
  - rd_ack while evt_valid=1 and there is no commit clears evt_valid on the next edge.
  - rd_ack with evt_valid=0 is ignored.
  - Commit with evt_valid=1 and rd_ack=0: evt_level is overwritten, evt_valid stays 1 and evt_miss is set.
  - Commit together with rd_ack: the new event is loaded, evt_valid stays 1 and evt_miss is not set.
  - clr does not affect evt_valid or evt_level.

Decomposition:
- Shared package latch_pkg holds the FSM state encodings (IDLE, CHECK) and the default parameter constants.
- One sub-module, sync_chain (parameter SYNC_STAGES; ports clk, rst, d, q), is instantiated once.
- The FSM, counter and handshake stay in the top module.

Test Plan:
All scenarios use the defaults (SYNC_STAGES=2, DEBOUNCE=4, CNT_W=8) unless stated.
- Reset/first change: hold rst=1 for 2 edges with q_in=1, then release.
  - During reset, all outputs are 0.
  - q_sync=1 at the 2nd edge after release; q_stable=1 and rise=1 for exactly one cycle at the 6th edge.
  - evt_cnt=1, evt_valid=1, evt_level=1.
- Glitch reject: q_in=1 for 3 cycles, then 0.
  - q_stable stays 0, there are no pulses, and evt_cnt is unchanged.
- Handshake overwrite: commit 0->1, then 1->0 with no ack.
  - evt_level=0, evt_valid=1, evt_miss=1.
  - One rd_ack gives evt_valid=0 on the next edge.
  - A commit in the same cycle as rd_ack keeps evt_valid=1 and leaves evt_miss unchanged.
- Saturation with CNT_W=2: 4 commits.
  - evt_cnt=3, ovf=1.
  - Pulse clr: evt_cnt=0, ovf=0, evt_miss=0.
- clr coincident with a commit: evt_cnt=0 after the edge, while rise/fall and evt_valid still behave as for a normal commit.
- Reset mid-debounce: q_in goes 0->1 and rst=1 is asserted while in CHECK with dbcnt=2.
  - After release with q_in still 1, the commit occurs on the 6th edge after release, not earlier.
